// File: rtl/gate_sweep_pkg.sv
// Shared constants and state encoding for the gate sweep sequencer.
package gate_sweep_pkg;

   localparam int unsigned NUM_VEC = 4;
   localparam int unsigned IDX_W   = 2;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned ERR_W   = 3;
   localparam int unsigned ST_W    = 3;

   localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
   localparam logic [ST_W-1:0] ST_DRIVE  = 3'd1;
   localparam logic [ST_W-1:0] ST_WAIT   = 3'd2;
   localparam logic [ST_W-1:0] ST_SAMPLE = 3'd3;
   localparam logic [ST_W-1:0] ST_DONE   = 3'd4;

   typedef enum logic [ST_W-1:0] {
      S_IDLE   = ST_IDLE,
      S_DRIVE  = ST_DRIVE,
      S_WAIT   = ST_WAIT,
      S_SAMPLE = ST_SAMPLE,
      S_DONE   = ST_DONE
   } state_t;

   // Truth tables: bit i is f for {a,b} = i.
   localparam logic [NUM_VEC-1:0] AND_TT = 4'b1000;
   localparam logic [NUM_VEC-1:0] OR_TT  = 4'b1110;
   localparam logic [NUM_VEC-1:0] XOR_TT = 4'b0110;

endpackage

// File: rtl/gate_sweep_ctrl_settle_timer.sv
// Loadable 4-bit down-counter; expire is high in the cycle the count reads 1.
module settle_timer
   import gate_sweep_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expire
);

   logic [CNT_W-1:0] cnt;

   // Count down to zero; expire is registered alongside the count it describes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         expire <= 1'b0;
      end else if (load) begin
         cnt    <= load_val;
         expire <= (load_val == CNT_W'(1));
      end else if (cnt != '0) begin
         cnt    <= cnt - CNT_W'(1);
         expire <= (cnt == CNT_W'(2));
      end else begin
         expire <= 1'b0;
      end
   end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer: drives ab = 00..11, waits SETTLE cycles, checks f against EXPECT.
module gate_sweep_ctrl
   import gate_sweep_pkg::*;
#(
   parameter logic [NUM_VEC-1:0] EXPECT = AND_TT,
   parameter int unsigned        SETTLE = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic               f,
   output logic               a,
   output logic               b,
   output logic               busy,
   output logic [IDX_W-1:0]   vec_idx,
   output logic               done,
   output logic               pass,
   output logic [NUM_VEC-1:0] fail_vec,
   output logic [ERR_W-1:0]   err_cnt
);

   state_t             state, state_nx;
   logic               a_nx, b_nx, busy_nx, done_nx, pass_nx;
   logic [IDX_W-1:0]   vec_idx_nx;
   logic [NUM_VEC-1:0] fail_vec_nx;
   logic [ERR_W-1:0]   err_cnt_nx;
   logic               load_c, expire, mismatch_c;

   assign mismatch_c = (f != EXPECT[vec_idx]);

   settle_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (load_c),
      .load_val (CNT_W'(SETTLE)),
      .expire   (expire)
   );

   // State and all outputs registered together; outputs reflect the state being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         a        <= 1'b0;
         b        <= 1'b0;
         busy     <= 1'b0;
         vec_idx  <= '0;
         done     <= 1'b0;
         pass     <= 1'b0;
         fail_vec <= '0;
         err_cnt  <= '0;
      end else begin
         state    <= state_nx;
         a        <= a_nx;
         b        <= b_nx;
         busy     <= busy_nx;
         vec_idx  <= vec_idx_nx;
         done     <= done_nx;
         pass     <= pass_nx;
         fail_vec <= fail_vec_nx;
         err_cnt  <= err_cnt_nx;
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      state_nx    = state;
      a_nx        = a;
      b_nx        = b;
      vec_idx_nx  = vec_idx;
      pass_nx     = pass;
      fail_vec_nx = fail_vec;
      err_cnt_nx  = err_cnt;
      load_c      = 1'b0;

      case (state)
         S_IDLE: begin
            a_nx = 1'b0;
            b_nx = 1'b0;
            if (start) begin
               state_nx    = S_DRIVE;
               vec_idx_nx  = '0;
               fail_vec_nx = '0;
               err_cnt_nx  = '0;
               pass_nx     = 1'b0;
            end
         end
         S_DRIVE, S_WAIT, S_SAMPLE: begin
            if (abort) begin
               state_nx = S_IDLE;
               a_nx     = 1'b0;
               b_nx     = 1'b0;
               pass_nx  = 1'b0;
            end else if (state == S_DRIVE) begin
               {a_nx, b_nx} = vec_idx;
               load_c       = 1'b1;
               state_nx     = (SETTLE == 0) ? S_SAMPLE : S_WAIT;
            end else if (state == S_WAIT) begin
               if (expire) state_nx = S_SAMPLE;
            end else begin
               if (mismatch_c) begin
                  fail_vec_nx[vec_idx] = 1'b1;
                  err_cnt_nx           = err_cnt + ERR_W'(1);
               end
               if (vec_idx == IDX_W'(NUM_VEC - 1)) begin
                  state_nx = S_DONE;
                  a_nx     = 1'b0;
                  b_nx     = 1'b0;
                  pass_nx  = (err_cnt == '0) && !mismatch_c;
               end else begin
                  vec_idx_nx = vec_idx + IDX_W'(1);
                  state_nx   = S_DRIVE;
               end
            end
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase

      busy_nx = (state_nx == S_DRIVE) || (state_nx == S_WAIT) || (state_nx == S_SAMPLE);
      done_nx = (state_nx == S_DONE);
   end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Randomized bench for gate_sweep_ctrl: two instances (SETTLE=2 and SETTLE=0) against a timing model.
module tb_gate_sweep_ctrl;
   import gate_sweep_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [3:0] gate_tt = AND_TT;
   logic       sel = 1'b0;
   int         nvec = 0;
   int         nerr = 0;

   logic       start_m = 1'b0, abort_m = 1'b0, f_m, a_m, b_m, busy_m, done_m, pass_m;
   logic [1:0] vi_m;
   logic [3:0] fv_m;
   logic [2:0] ec_m;
   logic       start_z = 1'b0, abort_z = 1'b0, f_z, a_z, b_z, busy_z, done_z, pass_z;
   logic [1:0] vi_z;
   logic [3:0] fv_z;
   logic [2:0] ec_z;

   // Gate under test: behavioural lookup of the current truth table.
   assign f_m = gate_tt[{a_m, b_m}];
   assign f_z = gate_tt[{a_z, b_z}];

   gate_sweep_ctrl dut (
      .clk(clk), .rst(rst), .start(start_m), .abort(abort_m), .f(f_m),
      .a(a_m), .b(b_m), .busy(busy_m), .vec_idx(vi_m), .done(done_m),
      .pass(pass_m), .fail_vec(fv_m), .err_cnt(ec_m)
   );

   gate_sweep_ctrl #(.EXPECT(AND_TT), .SETTLE(0)) dut0 (
      .clk(clk), .rst(rst), .start(start_z), .abort(abort_z), .f(f_z),
      .a(a_z), .b(b_z), .busy(busy_z), .vec_idx(vi_z), .done(done_z),
      .pass(pass_z), .fail_vec(fv_z), .err_cnt(ec_z)
   );

   logic       o_a, o_b, o_busy, o_done, o_pass;
   logic [1:0] o_vi;
   logic [3:0] o_fv;
   logic [2:0] o_ec;
   assign o_a    = sel ? a_z    : a_m;
   assign o_b    = sel ? b_z    : b_m;
   assign o_busy = sel ? busy_z : busy_m;
   assign o_done = sel ? done_z : done_m;
   assign o_pass = sel ? pass_z : pass_m;
   assign o_vi   = sel ? vi_z   : vi_m;
   assign o_fv   = sel ? fv_z   : fv_m;
   assign o_ec   = sel ? ec_z   : ec_m;

   function automatic int popcnt4(input logic [3:0] v);
      int n = 0;
      for (int i = 0; i < 4; i++) n += int'(v[i]);
      return n;
   endfunction

   task automatic set_start(input logic v);
      if (sel) start_z = v; else start_m = v;
   endtask

   // One full sweep on the selected instance, checked cycle by cycle against the timing model.
   task automatic run_sweep(input logic s, input logic [3:0] tt, input bit hold,
                            input int pulse_at, input string name);
      int p, last, exp_ab, exp_vi;
      logic [3:0] efv;
      sel     = s;
      gate_tt = tt;
      p       = (s ? 0 : 2) + 2;
      last    = 4 * p + 1;
      efv     = tt ^ AND_TT;
      @(negedge clk);
      nvec++;
      if (o_busy !== 1'b0 || o_done !== 1'b0) begin
         nerr++;
         $display("FAIL %s idle_before_start: busy=%b done=%b want 0 0", name, o_busy, o_done);
      end
      set_start(1'b1);
      for (int k = 1; k <= last; k++) begin
         @(negedge clk);
         if (k == 1 && !hold) set_start(1'b0);
         if (k == pulse_at) set_start(1'b1);
         if (k == pulse_at + 1 && !hold) set_start(1'b0);
         exp_ab = (k >= 2 && k <= 4 * p) ? (k - 2) / p : 0;
         exp_vi = (k - 1) / p;
         nvec++;
         if ({o_a, o_b} !== 2'(exp_ab)) begin
            nerr++;
            $display("FAIL %s ab cyc%0d: got %b want %b", name, k, {o_a, o_b}, 2'(exp_ab));
         end
         nvec++;
         if (o_busy !== (k <= 4 * p)) begin
            nerr++;
            $display("FAIL %s busy cyc%0d: got %b want %b", name, k, o_busy, (k <= 4 * p));
         end
         nvec++;
         if (o_done !== (k == last)) begin
            nerr++;
            $display("FAIL %s done cyc%0d: got %b want %b", name, k, o_done, (k == last));
         end
         if (k <= 4 * p) begin
            nvec++;
            if (o_vi !== 2'(exp_vi)) begin
               nerr++;
               $display("FAIL %s vec_idx cyc%0d: got %0d want %0d", name, k, o_vi, exp_vi);
            end
         end
      end
      nvec++;
      if (o_pass !== (efv == 4'b0000) || o_fv !== efv || o_ec !== 3'(popcnt4(efv))) begin
         nerr++;
         $display("FAIL %s result: pass=%b fail_vec=%b err_cnt=%0d want %b %b %0d", name,
                  o_pass, o_fv, o_ec, (efv == 4'b0000), efv, popcnt4(efv));
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      nvec++;
      if ({a_m, b_m, busy_m, vi_m, done_m, pass_m, fv_m, ec_m} !== 14'd0) begin
         nerr++;
         $display("FAIL reset_main: got %b want all 0", {a_m, b_m, busy_m, vi_m, done_m, pass_m, fv_m, ec_m});
      end
      nvec++;
      if ({a_z, b_z, busy_z, vi_z, done_z, pass_z, fv_z, ec_z} !== 14'd0) begin
         nerr++;
         $display("FAIL reset_settle0: got %b want all 0", {a_z, b_z, busy_z, vi_z, done_z, pass_z, fv_z, ec_z});
      end
      rst = 1'b0;
   endtask

   task automatic test_good_and();
      run_sweep(1'b0, AND_TT, 1'b0, 0, "good_and");
   endtask

   task automatic test_or_gate();
      run_sweep(1'b0, OR_TT, 1'b0, 0, "or_gate");
      nvec++;
      if (fv_m !== 4'b0110 || ec_m !== 3'd2 || pass_m !== 1'b0) begin
         nerr++;
         $display("FAIL or_gate_const: fail_vec=%b err=%0d pass=%b want 0110 2 0", fv_m, ec_m, pass_m);
      end
   endtask

   task automatic test_settle0();
      run_sweep(1'b1, AND_TT, 1'b0, 0, "settle0_and");
      run_sweep(1'b1, XOR_TT, 1'b0, 0, "settle0_xor");
   endtask

   task automatic test_random();
      for (int i = 0; i < 10; i++) begin
         logic s;
         int   pa;
         s  = 1'($urandom);
         pa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 7)) : 0;
         run_sweep(s, 4'($urandom), 1'b0, pa, "random");
      end
   endtask

   // Abort mid-sweep, start+abort in IDLE, and abort during DONE.
   task automatic test_abort();
      logic [3:0] efv;
      bit         saw_done;
      sel = 1'b0;
      gate_tt = 4'($urandom);
      efv = (gate_tt ^ AND_TT) & 4'b0011;
      @(negedge clk);
      start_m = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) start_m = 1'b0;
      end
      abort_m = 1'b1;
      @(negedge clk);
      abort_m = 1'b0;
      nvec++;
      if (busy_m !== 1'b0 || {a_m, b_m} !== 2'b00 || pass_m !== 1'b0 || done_m !== 1'b0) begin
         nerr++;
         $display("FAIL abort_idle: busy=%b ab=%b pass=%b done=%b want 0 00 0 0", busy_m, {a_m, b_m}, pass_m, done_m);
      end
      nvec++;
      if (fv_m !== efv || ec_m !== 3'(popcnt4(efv))) begin
         nerr++;
         $display("FAIL abort_partial: fail_vec=%b err=%0d want %b %0d", fv_m, ec_m, efv, popcnt4(efv));
      end
      saw_done = 1'b0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (done_m === 1'b1 || busy_m === 1'b1) saw_done = 1'b1;
      end
      nvec++;
      if (saw_done) begin
         nerr++;
         $display("FAIL abort_no_done: got activity after abort want none");
      end

      gate_tt = AND_TT;
      start_m = 1'b1;
      abort_m = 1'b1;
      @(negedge clk);
      start_m = 1'b0;
      abort_m = 1'b0;
      nvec++;
      if (busy_m !== 1'b1) begin
         nerr++;
         $display("FAIL start_beats_abort: busy=%b want 1", busy_m);
      end
      saw_done = 1'b0;
      for (int k = 2; k <= 17; k++) begin
         @(negedge clk);
         if (k == 17) saw_done = done_m;
         if (k == 17) abort_m = 1'b1;
      end
      @(negedge clk);
      abort_m = 1'b0;
      nvec++;
      if (saw_done !== 1'b1 || pass_m !== 1'b1 || fv_m !== 4'b0000 || busy_m !== 1'b0) begin
         nerr++;
         $display("FAIL abort_in_done: done=%b pass=%b fail_vec=%b busy=%b want 1 1 0000 0", saw_done, pass_m, fv_m, busy_m);
      end
   endtask

   task automatic test_reset_mid();
      sel = 1'b0;
      gate_tt = 4'b0111;
      @(negedge clk);
      start_m = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) start_m = 1'b0;
      end
      nvec++;
      if (fv_m !== 4'b0001 || ec_m !== 3'd1 || {a_m, b_m} !== 2'b01) begin
         nerr++;
         $display("FAIL pre_reset: fail_vec=%b err=%0d ab=%b want 0001 1 01", fv_m, ec_m, {a_m, b_m});
      end
      rst = 1'b1;
      #1;
      nvec++;
      if ({a_m, b_m, busy_m, vi_m, done_m, pass_m, fv_m, ec_m} !== 14'd0) begin
         nerr++;
         $display("FAIL reset_mid: got %b want all 0", {a_m, b_m, busy_m, vi_m, done_m, pass_m, fv_m, ec_m});
      end
      @(negedge clk);
      rst = 1'b0;
      run_sweep(1'b0, AND_TT, 1'b0, 0, "after_reset");
   endtask

   // Start held across two sweeps with an extra pulse in the second; nothing runs afterwards.
   task automatic test_back_to_back();
      bit extra;
      run_sweep(1'b0, AND_TT, 1'b1, 0, "b2b_first");
      run_sweep(1'b0, AND_TT, 1'b0, 6, "b2b_second");
      extra = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (busy_m === 1'b1 || done_m === 1'b1) extra = 1'b1;
      end
      nvec++;
      if (extra) begin
         nerr++;
         $display("FAIL b2b_no_third: got extra sweep want none");
      end
   endtask

   initial begin
      test_reset();
      test_good_and();
      test_or_gate();
      test_settle0();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
